recip_div_seq: RTL and testbench

Sequencing and scaling stage wrapped around the fixed-point reciprocal unit. It performs signed Q(W-F).F division q = num / den as num * (1/|den|):
- Accepts a request on a valid/ready handshake.
- Drives the reciprocal unit with |den| and a one-cycle start pulse, then waits for its done, with a timeout.
- Multiplies |num| by the returned reciprocal with rounding, sign and saturation.
- Holds the result on a valid/ready output.

---
 rtl/recip_pkg.sv | 23 ++
 rtl/recip_div_seq_if.sv | 39 +++
 rtl/qmul_round_sat.sv | 70 +++++++
 rtl/recip_div_seq.sv | 164 ++++++++++++++++
 tb/tb_recip_div_seq.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/recip_pkg.sv
// Shared types and Q-format defaults for the
// reciprocal-based signed divider slice.
`timescale 1ns/1ps
package recip_pkg;

    localparam int W_DEF = 32;
    localparam int F_DEF = 16;

    // Half of one output LSB in the default Q format,
    // added before the >>F to round half-up.
    localparam longint unsigned HALF_LSB =
        64'd1 << (F_DEF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_MUL,
        S_SAT,
        S_OUT
    } recip_div_st_t;

endpackage

// File: rtl/recip_div_seq_if.sv
// Request/result handshake bundle of recip_div_seq.
// master = requester/consumer, slave = divider.
`timescale 1ns/1ps
interface recip_div_seq_if #(
    parameter int W = 32
) ();

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_num;
    logic [W-1:0] req_den;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_q;
    logic         res_err_div0;
    logic         res_err_inv;
    logic         res_err_timeout;
    logic         res_sat;

    modport master (
        output req_valid, req_num, req_den,
        output res_ready,
        input  req_ready,
        input  res_valid, res_q, res_err_div0,
        input  res_err_inv, res_err_timeout,
        input  res_sat
    );

    modport slave (
        input  req_valid, req_num, req_den,
        input  res_ready,
        output req_ready,
        output res_valid, res_q, res_err_div0,
        output res_err_inv, res_err_timeout,
        output res_sat
    );

endinterface

// File: rtl/qmul_round_sat.sv
// Unsigned |num|*recip multiply with round-half-up
// (registered on en), then signed saturation.
// Ports: clk, rst_n, en (capture product), neg (sign
// of result), a/b (unsigned operands), q (signed
// result), sat (result clipped).
`timescale 1ns/1ps
module qmul_round_sat
    import recip_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int F = F_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         neg,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic         sat
);

    localparam int RW = 2 * W - F;

    // Product of a <= 2^(W-1) and b < 2^W stays below
    // 2^(2W-1), so adding the half LSB cannot carry out.
    localparam logic [2*W-1:0] HALF =
        (2 * W)'(1) << (F - 1);

    localparam logic [RW-1:0] POS_MAX =
        (RW'(1) << (W - 1)) - RW'(1);
    localparam logic [RW-1:0] NEG_MAX =
        RW'(1) << (W - 1);

    logic [2*W-1:0] prod;
    logic [RW-1:0]  rnd;
    logic [W-1:0]   mag;

    assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd <= '0;
        end else if (en) begin
            rnd <= RW'((prod + HALF) >> F);
        end
    end

    // Negative results may reach -2^(W-1), one step
    // further than positive ones.
    always_comb begin
        sat = 1'b0;
        mag = W'(rnd);
        q   = '0;
        if (!neg) begin
            if (rnd > POS_MAX) begin
                sat = 1'b1;
                mag = W'(POS_MAX);
            end
            q = mag;
        end else begin
            if (rnd > NEG_MAX) begin
                sat = 1'b1;
                mag = W'(NEG_MAX);
            end
            q = ~mag + W'(1);
        end
    end

endmodule

// File: rtl/recip_div_seq.sv
// Signed Q(W-F).F divider q = num * (1/|den|) that
// sequences an external reciprocal unit.
// Ports: clk, rst_n; bus (req/res handshakes);
// start_calc/x_in to the reciprocal unit;
// recip_done/recip_x_inv/recip_invalid from it.
`timescale 1ns/1ps
module recip_div_seq
    import recip_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int F       = F_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    recip_div_seq_if.slave bus,
    output logic           start_calc,
    output logic [W-1:0]   x_in,
    input  logic           recip_done,
    input  logic [W-1:0]   recip_x_inv,
    input  logic           recip_invalid
);

    localparam int CW = $clog2(TIMEOUT + 1);

    recip_div_st_t st, st_nxt;

    logic [W-1:0]  num_mag;
    logic [W-1:0]  x_inv;
    logic          neg;
    logic [CW-1:0] cnt;
    logic [W-1:0]  q_r;
    logic          div0_r;
    logic          inv_r;
    logic          to_r;
    logic          sat_r;

    logic          req_ready_c;
    logic          res_valid_c;
    logic          den_zero;
    logic          wait_to;
    logic [W-1:0]  mul_q;
    logic          mul_sat;

    // Two's-complement magnitude; -2^(W-1) maps to
    // 2^(W-1) as an unsigned value.
    function automatic logic [W-1:0] mag(
        input logic [W-1:0] v
    );
        return v[W-1] ? (~v + W'(1)) : v;
    endfunction

    assign den_zero = (bus.req_den == '0);
    assign wait_to  = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= S_IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt      = st;
        req_ready_c = 1'b0;
        start_calc  = 1'b0;
        res_valid_c = 1'b0;
        unique case (st)
            S_IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid)
                    st_nxt = den_zero ? S_OUT : S_START;
            end
            S_START: begin
                start_calc = 1'b1;
                st_nxt     = S_WAIT;
            end
            S_WAIT: begin
                if (recip_done)
                    st_nxt = recip_invalid ? S_OUT : S_MUL;
                else if (wait_to)
                    st_nxt = S_OUT;
            end
            S_MUL: st_nxt = S_SAT;
            S_SAT: st_nxt = S_OUT;
            S_OUT: begin
                res_valid_c = 1'b1;
                if (bus.res_ready) st_nxt = S_IDLE;
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_mag <= '0;
            x_in    <= '0;
            x_inv   <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            q_r     <= '0;
            div0_r  <= 1'b0;
            inv_r   <= 1'b0;
            to_r    <= 1'b0;
            sat_r   <= 1'b0;
        end else begin
            unique case (st)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        num_mag <= mag(bus.req_num);
                        x_in    <= mag(bus.req_den);
                        neg     <= bus.req_num[W-1]
                                 ^ bus.req_den[W-1];
                        div0_r  <= den_zero;
                        inv_r   <= 1'b0;
                        to_r    <= 1'b0;
                        sat_r   <= 1'b0;
                        if (den_zero) q_r <= '0;
                    end
                end
                S_START: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (recip_done) begin
                        x_inv <= recip_x_inv;
                        if (recip_invalid) begin
                            inv_r <= 1'b1;
                            q_r   <= '0;
                        end
                    end else if (wait_to) begin
                        to_r <= 1'b1;
                        q_r  <= '0;
                    end
                end
                S_SAT: begin
                    q_r   <= mul_q;
                    sat_r <= mul_sat;
                end
                default: ;
            endcase
        end
    end

    qmul_round_sat #(
        .W (W),
        .F (F)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (st == S_MUL),
        .neg   (neg),
        .a     (num_mag),
        .b     (x_inv),
        .q     (mul_q),
        .sat   (mul_sat)
    );

    assign bus.req_ready       = req_ready_c;
    assign bus.res_valid       = res_valid_c;
    assign bus.res_q           = q_r;
    assign bus.res_err_div0    = div0_r;
    assign bus.res_err_inv     = inv_r;
    assign bus.res_err_timeout = to_r;
    assign bus.res_sat         = sat_r;

endmodule

// File: tb/tb_recip_div_seq.sv
// Scoreboard bench for recip_div_seq with a
// behavioural reciprocal unit of programmable latency.
`timescale 1ns/1ps
module tb_recip_div_seq;
    import recip_pkg::*;

    localparam int W  = 32;
    localparam int F  = 16;
    localparam int TO = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    recip_div_seq_if #(.W(W)) bus ();

    logic         start_calc;
    logic [W-1:0] x_in;
    logic         recip_done    = 1'b0;
    logic [W-1:0] recip_x_inv   = '0;
    logic         recip_invalid;

    recip_div_seq #(
        .W       (W),
        .F       (F),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .start_calc    (start_calc),
        .x_in          (x_in),
        .recip_done    (recip_done),
        .recip_x_inv   (recip_x_inv),
        .recip_invalid (recip_invalid)
    );

    // The modelled unit rejects a negative x_in.
    assign recip_invalid = x_in[W-1];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h",
                     name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- reciprocal unit model
    int           m_lat    = 1;
    logic [W-1:0] m_xinv   = '0;
    bit           m_never  = 1'b0;
    bit           m_inject = 1'b0;
    bit           m_act    = 1'b0;
    int           m_rem    = 0;
    int           n_start  = 0;
    logic [W-1:0] m_xin_cap;

    initial forever begin
        @(posedge clk);
        #1;
        recip_done = 1'b0;
        if (!rst_n) m_act = 1'b0;
        if (m_inject) begin
            recip_done  = 1'b1;
            recip_x_inv = 32'h0000_4000;
            m_inject    = 1'b0;
        end
        if (m_act) begin
            m_rem--;
            if (m_rem == 0) begin
                recip_done  = 1'b1;
                recip_x_inv = m_xinv;
                m_act       = 1'b0;
                chk("x_in_stable", x_in, m_xin_cap);
            end
        end
        if (start_calc) begin
            n_start++;
            m_xin_cap = x_in;
            if (!m_never) begin
                m_act = 1'b1;
                m_rem = m_lat;
            end
        end
    end

    // ---------------- scoreboard monitor
    typedef struct {
        logic [W-1:0] q;
        bit           div0;
        bit           inv;
        bit           to;
        bit           sat;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   acc_cyc = 0;
    int   n_out   = 0;
    bit   seen    = 1'b0;

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n || !bus.res_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            n_out++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got q=%h required none",
                         bus.res_q);
            end else begin
                e = sb.pop_front();
                chk("res_q", bus.res_q, e.q);
                chk("err_div0", W'(bus.res_err_div0), W'(e.div0));
                chk("err_inv", W'(bus.res_err_inv), W'(e.inv));
                chk("err_timeout", W'(bus.res_err_timeout), W'(e.to));
                chk("res_sat", W'(bus.res_sat), W'(e.sat));
                chk("latency", W'(cyc - acc_cyc), W'(e.lat));
            end
        end
    end

    // ---------------- directed vectors
    typedef struct {
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [W-1:0] xinv;
        int           lat;
        bit           never;
        bit           stall;
        logic [W-1:0] q;
        bit           div0;
        bit           inv;
        bit           to;
        bit           sat;
        int           elat;
        int           starts;
        logic [W-1:0] xin;
    } vec_t;

    function automatic vec_t mk(
        input logic [W-1:0] num, den, xinv,
        input int lat, input bit never, stall,
        input logic [W-1:0] q,
        input bit div0, inv, to, sat,
        input int elat, starts,
        input logic [W-1:0] xin);
        vec_t v;
        v.num = num;   v.den = den;   v.xinv = xinv;
        v.lat = lat;   v.never = never;
        v.stall = stall;
        v.q = q;       v.div0 = div0; v.inv = inv;
        v.to = to;     v.sat = sat;   v.elat = elat;
        v.starts = starts;            v.xin = xin;
        return v;
    endfunction

    localparam int NV = 11;
    vec_t vecs[NV];

    task automatic run_vec(input vec_t v);
        int s0;
        int o0;
        int k;
        m_lat  = v.lat;
        m_xinv = v.xinv;
        m_never = v.never;
        bus.res_ready = !v.stall;
        sb.push_back('{v.q, v.div0, v.inv, v.to,
                       v.sat, v.elat});
        s0 = n_start;
        o0 = n_out;
        @(posedge clk);
        #1;
        chk("req_ready_idle", W'(bus.req_ready), W'(1));
        bus.req_valid = 1'b1;
        bus.req_num   = v.num;
        bus.req_den   = v.den;
        acc_cyc       = cyc;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("req_ready_busy", W'(bus.req_ready), W'(0));
        chk("start_calc_c1", W'(start_calc), W'(v.starts));
        if (v.starts != 0) chk("x_in", x_in, v.xin);
        k = 0;
        while (n_out == o0 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_out == o0) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_result: got no res_valid in 200 cycles required res_valid");
            void'(sb.pop_front());
        end
        if (v.stall) begin
            repeat (5) begin
                @(negedge clk);
                chk("stall_valid", W'(bus.res_valid), W'(1));
                chk("stall_q", bus.res_q, v.q);
                chk("stall_sat", W'(bus.res_sat), W'(v.sat));
                chk("stall_req_ready", W'(bus.req_ready), W'(0));
            end
            @(posedge clk);
            #1;
            bus.res_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("post_hs_req_ready", W'(bus.req_ready), W'(1));
        chk("post_hs_valid", W'(bus.res_valid), W'(0));
        chk("start_count", W'(n_start - s0), W'(v.starts));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, W'(bus.req_ready), W'(1));
        chk({tag, "_start"}, W'(start_calc), W'(0));
        chk({tag, "_x_in"}, x_in, '0);
        chk({tag, "_valid"}, W'(bus.res_valid), W'(0));
        chk({tag, "_q"}, bus.res_q, '0);
        chk({tag, "_flags"},
            W'({bus.res_err_div0, bus.res_err_inv,
                bus.res_err_timeout, bus.res_sat}), W'(0));
    endtask

    initial begin
        vecs[0]  = mk(32'h000A0000, 32'h00040000, 32'h00004000,
                      12, 0, 0, 32'h00028000, 0, 0, 0, 0,
                      16, 1, 32'h00040000);
        vecs[1]  = mk(32'h000A0000, 32'hFFFC0000, 32'h00004000,
                      3, 0, 0, 32'hFFFD8000, 0, 0, 0, 0,
                      7, 1, 32'h00040000);
        vecs[2]  = mk(32'h00000001, 32'h00020000, 32'h00008000,
                      1, 0, 0, 32'h00000001, 0, 0, 0, 0,
                      5, 1, 32'h00020000);
        vecs[3]  = mk(32'hFFFFFFFF, 32'h00010000, 32'h00010000,
                      2, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0,
                      6, 1, 32'h00010000);
        vecs[4]  = mk(32'h000A0000, 32'h00000000, 32'h00004000,
                      2, 0, 0, 32'h00000000, 1, 0, 0, 0,
                      1, 0, 32'h00000000);
        vecs[5]  = mk(32'h000A0000, 32'h80000000, 32'h00004000,
                      4, 0, 0, 32'h00000000, 0, 1, 0, 0,
                      6, 1, 32'h80000000);
        vecs[6]  = mk(32'h7FFF0000, 32'h00010000, 32'h00100000,
                      2, 0, 0, 32'h7FFFFFFF, 0, 0, 0, 1,
                      6, 1, 32'h00010000);
        vecs[7]  = mk(32'h7FFF0000, 32'hFFFF0000, 32'h00100000,
                      2, 0, 0, 32'h80000000, 0, 0, 0, 1,
                      6, 1, 32'h00010000);
        vecs[8]  = mk(32'h80000000, 32'h00010000, 32'h00010000,
                      2, 0, 0, 32'h80000000, 0, 0, 0, 0,
                      6, 1, 32'h00010000);
        vecs[9]  = mk(32'h000A0000, 32'h00040000, 32'h00004000,
                      2, 1, 0, 32'h00000000, 0, 0, 1, 0,
                      TO + 2, 1, 32'h00040000);
        vecs[10] = mk(32'h000A0000, 32'h00040000, 32'h00004000,
                      2, 0, 1, 32'h00028000, 0, 0, 0, 0,
                      6, 1, 32'h00040000);

        bus.req_valid = 1'b0;
        bus.req_num   = '0;
        bus.req_den   = '0;
        bus.res_ready = 1'b1;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
            if (vecs[i].never) begin
                m_inject = 1'b1;
                repeat (3) @(negedge clk);
                chk("late_done_valid", W'(bus.res_valid), W'(0));
                chk("late_done_ready", W'(bus.req_ready), W'(1));
            end
        end

        // Abort mid-wait with an asynchronous reset.
        m_never = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_num   = 32'h000A0000;
        bus.req_den   = 32'h00040000;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_no_pending", W'(bus.res_valid), W'(0));
        chk("rst_ready", W'(bus.req_ready), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang required finish");
        $fatal(1);
    end

endmodule
